// File: rtl/zf_symbol_packer.sv
// Packs FFT output samples four-per-beat into OFDM symbols for the equalizer.
// Optional pilot tap on lane 3 of pilot beats is enabled by defining ZF_PILOT_TAP_EN.
//
// state | meaning
// RUN   | accepting samples and packing them into beats
// PAD   | input stalled, emitting zero beats until the symbol is complete
module zf_symbol_packer #(
    parameter int SYM_BEATS   = 256,
    parameter int PILOT_FIRST = 27,
    parameter int PILOT_LAST  = 227
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [31:0]  s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [31:0]  m_pilot_tdata,
    output logic         m_pilot_tvalid,
    output logic         frame_err
);

    localparam int BW = (SYM_BEATS > 1) ? $clog2(SYM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(SYM_BEATS - 1);

    typedef enum logic {RUN, PAD} state_t;

    state_t         state, state_nxt;
    logic [1:0]     lane_cnt, lane_nxt;
    logic [BW-1:0]  beat_cnt, beat_nxt;
    logic [31:0]    acc [3];
    logic [1:0]     occ, occ_nxt;
    logic [127:0]   head_data, skid_data;
    logic           head_last, skid_last;

    logic           accept, pop, push, at_last, close_beat, err_event;
    logic [127:0]   push_data;

    assign accept     = s_axis_tvalid & s_axis_tready;
    assign pop        = (occ != 2'd0) & m_axis_tready;
    assign at_last    = (beat_cnt == LAST_BEAT);
    assign close_beat = accept & ((lane_cnt == 2'd3) | s_axis_tlast);
    assign push       = (state == RUN) ? close_beat : (occ != 2'd2);
    assign occ_nxt    = occ + {1'b0, push} - {1'b0, pop};
    // Framing is correct only when tlast coincides exactly with lane 3 of the final beat.
    assign err_event  = close_beat & (s_axis_tlast != ((lane_cnt == 2'd3) & at_last));

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = head_data;
    assign m_axis_tlast  = head_last;

    always_comb begin
        push_data = '0;
        if (state == RUN) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < lane_cnt) push_data[32*i +: 32] = acc[i];
            end
            push_data[32*lane_cnt +: 32] = s_axis_tdata;
        end
    end

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane_cnt;
        beat_nxt  = beat_cnt;
        if (state == RUN) begin
            if (close_beat) begin
                lane_nxt = 2'd0;
                beat_nxt = at_last ? '0 : beat_cnt + BW'(1);
                if (s_axis_tlast && !at_last) state_nxt = PAD;
            end else if (accept) begin
                lane_nxt = lane_cnt + 2'd1;
            end
        end else if (push) begin
            beat_nxt = at_last ? '0 : beat_cnt + BW'(1);
            if (at_last) state_nxt = RUN;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= RUN;
            lane_cnt      <= 2'd0;
            beat_cnt      <= '0;
            acc[0]        <= '0;
            acc[1]        <= '0;
            acc[2]        <= '0;
            occ           <= 2'd0;
            head_data     <= '0;
            head_last     <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            s_axis_tready <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            lane_cnt  <= lane_nxt;
            beat_cnt  <= beat_nxt;
            occ       <= occ_nxt;
            frame_err <= err_event;
            // Ready is precomputed from next occupancy so it also stays low during reset.
            s_axis_tready <= (occ_nxt != 2'd2) && (state_nxt == RUN);

            if (accept && !close_beat) begin
                case (lane_cnt)
                    2'd0:    acc[0] <= s_axis_tdata;
                    2'd1:    acc[1] <= s_axis_tdata;
                    2'd2:    acc[2] <= s_axis_tdata;
                    default: ;
                endcase
            end

            case (occ)
                2'd0: begin
                    if (push) begin
                        head_data <= push_data;
                        head_last <= at_last;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= push_data;
                        head_last <= at_last;
                    end else if (push) begin
                        skid_data <= push_data;
                        skid_last <= at_last;
                    end
                end
                default: begin
                    if (pop) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                    end
                end
            endcase
        end
    end

`ifdef ZF_PILOT_TAP_EN
    localparam logic [BW-1:0] P_FIRST = BW'(PILOT_FIRST);
    localparam logic [BW-1:0] P_LAST  = BW'(PILOT_LAST);

    logic in_pilot;
    assign in_pilot = (beat_cnt >= P_FIRST) && (beat_cnt <= P_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_pilot_tvalid <= 1'b0;
            m_pilot_tdata  <= '0;
        end else begin
            m_pilot_tvalid <= push & in_pilot;
            if (push && in_pilot) m_pilot_tdata <= push_data[127:96];
        end
    end
`else
    assign m_pilot_tvalid = 1'b0;
    assign m_pilot_tdata  = '0;
`endif

endmodule

// File: doc/zf_symbol_packer.md
ZF_SYMBOL_PACKER -- requirements
Module: zf_symbol_packer

Interface
REQ-001 SHALL have parameter SYM_BEATS, default 256: output beats per OFDM symbol.
REQ-002 SHALL have parameter PILOT_FIRST, default 27: first beat index carrying a pilot.
REQ-003 SHALL have parameter PILOT_LAST, default 227: last beat index carrying a pilot.
REQ-004 SHALL have port aclk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports s_axis_tdata input 32 ({Q[15:0],I[15:0]}), s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1: FFT output, one complex sample per beat.
REQ-007 SHALL have ports m_axis_tdata output 128, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: four samples per beat, to the equalizer.
REQ-008 SHALL have ports m_pilot_tdata output 32, m_pilot_tvalid output 1: pilot tap, no backpressure.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on framing error.

Function
REQ-010 SHALL pack four accepted input samples into one output beat, lanes in arrival order: first at [31:0], fourth at [127:96].
REQ-011 SHALL hold output in a 2-entry skid buffer; s_axis_tready = 1 whenever the buffer holds fewer than 2 beats and state is RUN.
REQ-012 SHALL present a packed beat on m_axis one cycle after its fourth sample is accepted (buffer empty, m_axis_tready high).
REQ-013 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; no beat dropped or duplicated.
REQ-014 SHALL keep 2-bit lane counter (0..3) and beat counter (0..SYM_BEATS-1); beat counter increments per packed beat, wraps to 0 after SYM_BEATS-1.
REQ-015 SHALL assert m_axis_tlast on the beat with beat index SYM_BEATS-1 only.
REQ-016 SHALL implement states RUN and PAD; reset state RUN.
REQ-017 Early tlast (s_axis_tlast on a sample that is not lane 3 of beat SYM_BEATS-1): SHALL zero-fill unfilled lanes of the current beat, emit it, pulse frame_err the cycle after acceptance; if that beat index < SYM_BEATS-1, go to PAD, else stay RUN with counters reset to 0.
REQ-018 PAD: s_axis_tready=0; SHALL emit all-zero beats, one per available buffer slot, until beat SYM_BEATS-1 (tlast=1) is buffered, then return to RUN with counters 0.
REQ-019 Missing tlast (lane 3 of beat SYM_BEATS-1 accepted with s_axis_tlast=0): SHALL emit beat with m_axis_tlast=1, pulse frame_err, wrap counters; no padding.
REQ-020 SHALL ignore s_axis_tdata/tlast when s_axis_tvalid=0 or s_axis_tready=0.
REQ-021 Simultaneous buffer push and pop SHALL leave occupancy unchanged and be lossless.
REQ-022 frame_err SHALL be one cycle per error event, even if events are back-to-back.

Reset
REQ-023 areset high SHALL immediately force: state RUN, counters 0, buffer empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_pilot_tvalid=0, m_pilot_tdata=0, frame_err=0, s_axis_tready=0.
REQ-024 After areset deasserts, s_axis_tready SHALL rise on the first aclk edge; a partial beat or PAD in progress at reset is discarded.

Configuration
REQ-025 Macro ZF_PILOT_TAP_EN defined: each beat with index in [PILOT_FIRST,PILOT_LAST] entering the buffer (including PAD beats) SHALL produce a one-cycle m_pilot_tvalid with m_pilot_tdata = lane 3 ([127:96]) of that beat, one cycle after buffering; exactly PILOT_LAST-PILOT_FIRST+1 (201) pulses per symbol.
REQ-026 Macro ZF_PILOT_TAP_EN undefined: pilot logic SHALL be absent; m_pilot_tvalid and m_pilot_tdata tied to 0.

Verification
REQ-027 1024 samples I=n, Q=-n, tlast on n=1023, m_axis_tready=1 -> 256 beats, beat 0 = {-3,3,-2,2,-1,1,0,0}, tlast only on beat 255, frame_err never.
REQ-028 Same stimulus, m_axis_tready random 50% -> identical beat sequence, s_axis_tready low only when buffer full.
REQ-029 tlast on sample 401 (beat 100, lane 1) -> beat 100 lanes 2-3 zero, beats 101-255 all zero with tlast on 255, frame_err one pulse, s_axis_tready=0 during PAD.
REQ-030 1024 samples, no tlast -> beat 255 carries tlast, one frame_err; next symbol starts at beat 0.
REQ-031 ZF_PILOT_TAP_EN defined, REQ-027 stimulus -> 201 pilot pulses, first m_pilot_tdata I=111, Q=-111 (sample 4*27+3), last I=911.
REQ-032 areset asserted mid-symbol at beat 50 lane 2 -> all outputs 0 immediately; post-reset symbol packs from lane 0/beat 0.
